// File: rtl/frame_cfg_regs.sv
// Double-buffered per-channel framer config bank: CPU writes shadows, a commit arms a channel,
// and the channel's frame_start copies shadow to active. Readback enabled by FRAME_CFG_RDBK_EN.
module frame_cfg_regs #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned BASE_ADDR = 200,
    parameter int unsigned STRIDE    = 4
) (
    input  logic                 clk,
    input  logic                 pRST,
    input  logic                 cpu_wr_n,
    input  logic                 cpu_rd_n,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic [31:0]          cpu_wdata,
    output logic [31:0]          cpu_rdata,
    input  logic [NUM_CH-1:0]    frame_start,
    output logic [NUM_CH*32-1:0] packet_head,
    output logic [NUM_CH*16-1:0] flag_set,
    output logic [NUM_CH*24-1:0] length_set,
    output logic [NUM_CH-1:0]    scramble,
    output logic [NUM_CH-1:0]    cfg_pending,
    output logic [NUM_CH-1:0]    cfg_valid,
    output logic                 error
);

    localparam int unsigned CommitOff = NUM_CH * STRIDE;
    localparam logic [31:0] ChMask    = 32'((64'd1 << NUM_CH) - 64'd1);

    typedef enum logic {StIdle, StArmed} ch_state_e;

    ch_state_e   r_state   [NUM_CH];
    ch_state_e   w_state_d [NUM_CH];
    logic [31:0] r_sh_head [NUM_CH];
    logic [15:0] r_sh_flag [NUM_CH];
    logic [23:0] r_sh_len  [NUM_CH];
    logic        r_sh_scr  [NUM_CH];
    logic [31:0] r_act_head[NUM_CH];
    logic [15:0] r_act_flag[NUM_CH];
    logic [23:0] r_act_len [NUM_CH];
    logic        r_act_scr [NUM_CH];
    logic [NUM_CH-1:0] r_valid;
    logic              r_error;
    logic [31:0]       r_rdata;

    logic [31:0]       w_rel;
    logic              w_in_win;
    logic              w_commit;
    logic              w_wr;
    logic [NUM_CH-1:0] w_hit;
    logic [31:0]       w_off;
    logic              w_unmapped;
    logic [NUM_CH-1:0] w_copy;
    logic [NUM_CH-1:0] w_pending;
    logic              w_err_d;
    logic [31:0]       w_rd_val;

    // Offset relative to the window base; wraps for addresses below the base, gated by w_in_win.
    assign w_rel    = 32'(cpu_addr) - BASE_ADDR;
    assign w_in_win = (32'(cpu_addr) >= BASE_ADDR) && (w_rel <= CommitOff);
    assign w_commit = w_in_win && (w_rel == CommitOff);
    assign w_wr     = !cpu_wr_n;

    always_comb begin
        w_hit = '0;
        w_off = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            if (w_in_win && (w_rel >= ch * STRIDE) && (w_rel < (ch + 1) * STRIDE)) begin
                w_hit[ch] = 1'b1;
                w_off     = w_rel - ch * STRIDE;
            end
        end
    end

    assign w_unmapped = (|w_hit) && (w_off >= 32'd4);

    always_comb begin
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            w_state_d[ch] = r_state[ch];
            w_copy[ch]    = 1'b0;
            case (r_state[ch])
                StIdle: begin
                    if (w_wr && w_commit && cpu_wdata[ch]) begin
                        w_state_d[ch] = StArmed;
                    end
                end
                StArmed: begin
                    if (frame_start[ch]) begin
                        w_copy[ch] = 1'b1;
                        // A commit landing on the copy edge re-arms for the following frame.
                        w_state_d[ch] = (w_wr && w_commit && cpu_wdata[ch]) ? StArmed : StIdle;
                    end
                end
                default: w_state_d[ch] = StIdle;
            endcase
            w_pending[ch] = (r_state[ch] == StArmed);
        end
    end

    always_comb begin
        w_rd_val = '0;
        if (w_commit) begin
            w_rd_val = 32'(w_pending);
        end
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            if (w_hit[ch]) begin
                case (w_off)
                    32'd0:   w_rd_val = r_sh_head[ch];
                    32'd1:   w_rd_val = {16'd0, r_sh_flag[ch]};
                    32'd2:   w_rd_val = {8'd0, r_sh_len[ch]};
                    32'd3:   w_rd_val = {31'd0, r_sh_scr[ch]};
                    default: w_rd_val = '0;
                endcase
            end
        end
    end

`ifdef FRAME_CFG_RDBK_EN
    assign w_err_d = (w_wr && (w_unmapped || (w_commit && |(cpu_wdata & ~ChMask))))
                   || (!w_wr && !cpu_rd_n && w_unmapped);

    always_ff @(posedge clk) begin
        if (pRST) begin
            r_rdata <= '0;
        end else if (!cpu_rd_n) begin
            r_rdata <= w_wr ? 32'd0 : w_rd_val;
        end
    end
`else
    logic [32:0] w_unused_rd;
    assign w_unused_rd = {cpu_rd_n, w_rd_val};
    assign w_err_d = w_wr && (w_unmapped || (w_commit && |(cpu_wdata & ~ChMask)));

    always_ff @(posedge clk) begin
        r_rdata <= '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (pRST) begin
            r_error <= 1'b0;
            r_valid <= '0;
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                r_state[ch]    <= StIdle;
                r_sh_head[ch]  <= '0;
                r_sh_flag[ch]  <= '0;
                r_sh_len[ch]   <= '0;
                r_sh_scr[ch]   <= 1'b0;
                r_act_head[ch] <= '0;
                r_act_flag[ch] <= '0;
                r_act_len[ch]  <= '0;
                r_act_scr[ch]  <= 1'b0;
            end
        end else begin
            r_error <= w_err_d;
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                r_state[ch] <= w_state_d[ch];
                if (w_wr && w_hit[ch]) begin
                    case (w_off)
                        32'd0:   r_sh_head[ch] <= cpu_wdata;
                        32'd1:   r_sh_flag[ch] <= cpu_wdata[15:0];
                        32'd2:   r_sh_len[ch]  <= cpu_wdata[23:0];
                        32'd3:   r_sh_scr[ch]  <= cpu_wdata[0];
                        default: ;
                    endcase
                end
                // Non-blocking copy samples the pre-write shadow on a same-edge write.
                if (w_copy[ch]) begin
                    r_act_head[ch] <= r_sh_head[ch];
                    r_act_flag[ch] <= r_sh_flag[ch];
                    r_act_len[ch]  <= r_sh_len[ch];
                    r_act_scr[ch]  <= r_sh_scr[ch];
                    r_valid[ch]    <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            packet_head[ch*32 +: 32] = r_act_head[ch];
            flag_set[ch*16 +: 16]    = r_act_flag[ch];
            length_set[ch*24 +: 24]  = r_act_len[ch];
            scramble[ch]             = r_act_scr[ch];
        end
    end

    assign cfg_pending = w_pending;
    assign cfg_valid   = r_valid;
    assign error       = r_error;
    assign cpu_rdata   = r_rdata;

endmodule

// File: tb/tb_frame_cfg_regs.sv
// Directed-vector bench for frame_cfg_regs: a default instance plus a STRIDE=5 instance
// for unmapped-offset errors. Readback expectations follow FRAME_CFG_RDBK_EN.
module tb_frame_cfg_regs;

`ifdef FRAME_CFG_RDBK_EN
    localparam logic RdbkEn = 1'b1;
`else
    localparam logic RdbkEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        pRST;
    logic        wr_n, rd_n, sel5;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  fs, fs5;

    wire wr_n_a = sel5 ? 1'b1 : wr_n;
    wire rd_n_a = sel5 ? 1'b1 : rd_n;
    wire wr_n_b = sel5 ? wr_n : 1'b1;
    wire rd_n_b = sel5 ? rd_n : 1'b1;

    logic [31:0]  rdata, rdata5;
    logic [127:0] head, head5;
    logic [63:0]  flag, flag5;
    logic [95:0]  len, len5;
    logic [3:0]   scr, pend, valid, scr5, pend5, valid5;
    logic         err, err5;

    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    frame_cfg_regs u_dut (
        .clk(clk), .pRST(pRST), .cpu_wr_n(wr_n_a), .cpu_rd_n(rd_n_a), .cpu_addr(addr),
        .cpu_wdata(wdata), .cpu_rdata(rdata), .frame_start(fs), .packet_head(head),
        .flag_set(flag), .length_set(len), .scramble(scr), .cfg_pending(pend),
        .cfg_valid(valid), .error(err)
    );

    frame_cfg_regs #(.STRIDE(5)) u_dut5 (
        .clk(clk), .pRST(pRST), .cpu_wr_n(wr_n_b), .cpu_rd_n(rd_n_b), .cpu_addr(addr),
        .cpu_wdata(wdata), .cpu_rdata(rdata5), .frame_start(fs5), .packet_head(head5),
        .flag_set(flag5), .length_set(len5), .scramble(scr5), .cfg_pending(pend5),
        .cfg_valid(valid5), .error(err5)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cpu_wr(input logic [8:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_n = 1'b0; addr = a; wdata = d;
        @(negedge clk);
        wr_n = 1'b1;
    endtask

    task automatic cpu_rd(input logic [8:0] a);
        @(negedge clk);
        rd_n = 1'b0; addr = a;
        @(negedge clk);
        rd_n = 1'b1;
    endtask

    task automatic pulse(input logic [3:0] v, input logic to5);
        @(negedge clk);
        if (to5) fs5 = v; else fs = v;
        @(negedge clk);
        fs = '0; fs5 = '0;
    endtask

    initial begin
        pRST = 1'b1; wr_n = 1'b1; rd_n = 1'b1; sel5 = 1'b0;
        addr = '0; wdata = '0; fs = '0; fs5 = '0;
        repeat (2) @(negedge clk);
        pRST = 1'b0;

        check("rst_head", head, '0);
        check("rst_pending", 128'(pend), 128'h0);
        check("rst_valid", 128'(valid), 128'h0);
        check("rst_rdata", 128'(rdata), 128'h0);
        check("rst_error", 128'(err), 128'h0);

        // Staged commit on ch0
        cpu_wr(9'd200, 32'hEB90_146F);
        cpu_wr(9'd202, 32'h0000_0800);
        cpu_wr(9'd216, 32'h1);
        check("armed_pending", 128'(pend), 128'h1);
        check("armed_head_hold", 128'(head[31:0]), 128'h0);
        pulse(4'b0001, 1'b0);
        check("copy_head", 128'(head[31:0]), 128'hEB90_146F);
        check("copy_len", 128'(len[23:0]), 128'h800);
        check("copy_valid", 128'(valid), 128'h1);
        check("copy_pending", 128'(pend), 128'h0);

        // frame_start while idle does nothing
        cpu_wr(9'd200, 32'h1234_5678);
        pulse(4'b0001, 1'b0);
        check("idle_fs_head", 128'(head[31:0]), 128'hEB90_146F);

        // Commit and frame_start on the same edge: arm only
        cpu_wr(9'd209, 32'h5555);
        @(negedge clk);
        wr_n = 1'b0; addr = 9'd216; wdata = 32'h4; fs = 4'b0100;
        @(negedge clk);
        wr_n = 1'b1; fs = '0;
        check("race_arm_pending", 128'(pend[2]), 128'h1);
        check("race_arm_flag", 128'(flag[47:32]), 128'h0);
        // Copy and shadow write on the same edge: active gets the old shadow
        @(negedge clk);
        wr_n = 1'b0; addr = 9'd209; wdata = 32'hAAAA; fs = 4'b0100;
        @(negedge clk);
        wr_n = 1'b1; fs = '0;
        check("race_copy_flag", 128'(flag[47:32]), 128'h5555);
        check("race_copy_valid", 128'(valid), 128'h5);
        // Last write while armed wins; unused wdata bits dropped
        cpu_wr(9'd216, 32'h4);
        cpu_wr(9'd210, 32'h0011_1111);
        cpu_wr(9'd210, 32'hFF22_2222);
        pulse(4'b0100, 1'b0);
        check("armed_flag_new", 128'(flag[47:32]), 128'hAAAA);
        check("armed_len_last", 128'(len[71:48]), 128'h22_2222);

        // Readback
        cpu_wr(9'd215, 32'hFFFF_FFFF);
        cpu_rd(9'd215);
        check("rd_scr", 128'(rdata), RdbkEn ? 128'h1 : 128'h0);
        @(negedge clk);
        check("rd_hold", 128'(rdata), RdbkEn ? 128'h1 : 128'h0);
        check("scr_active", 128'(scr), 128'h0);
        @(negedge clk);
        wr_n = 1'b0; rd_n = 1'b0; addr = 9'd215; wdata = 32'h0;
        @(negedge clk);
        wr_n = 1'b1; rd_n = 1'b1;
        check("rd_wr_same", 128'(rdata), 128'h0);
        cpu_wr(9'd216, 32'h1);
        cpu_rd(9'd216);
        check("rd_pending", 128'(rdata), RdbkEn ? 128'h1 : 128'h0);

        // Out-of-window and commit edge cases
        cpu_wr(9'd199, 32'hFFFF_FFFF);
        check("oow199_err", 128'(err), 128'h0);
        cpu_wr(9'd217, 32'hFFFF_FFFF);
        check("oow217_err", 128'(err), 128'h0);
        check("oow_pending", 128'(pend), 128'h1);
        cpu_wr(9'd216, 32'h0);
        check("commit0_pending", 128'(pend), 128'h1);
        cpu_wr(9'd216, 32'h8000_0003);
        check("commit_hi_err", 128'(err), 128'h1);
        check("commit_hi_pending", 128'(pend), 128'h3);
        @(negedge clk);
        check("err_one_cycle", 128'(err), 128'h0);

        // Reset while ch1 armed
        @(negedge clk);
        pRST = 1'b1;
        @(negedge clk);
        pRST = 1'b0;
        check("rst2_head", head, '0);
        check("rst2_flag_len", {flag, len[63:0]}, '0);
        check("rst2_pending", 128'(pend), 128'h0);
        check("rst2_valid", 128'(valid), 128'h0);
        check("rst2_rdata", 128'(rdata), 128'h0);
        pulse(4'b0010, 1'b0);
        check("rst2_fs_head", head, '0);
        check("rst2_fs_valid", 128'(valid), 128'h0);

        // STRIDE=5 instance: unmapped offset and stray commit bits
        sel5 = 1'b1;
        cpu_wr(9'd200, 32'hCAFE_0000);
        cpu_wr(9'd204, 32'hFFFF_FFFF);
        check("s5_unmapped_err", 128'(err5), 128'h1);
        @(negedge clk);
        check("s5_err_clear", 128'(err5), 128'h0);
        cpu_wr(9'd220, 32'h8000_0003);
        check("s5_commit_err", 128'(err5), 128'h1);
        check("s5_pending", 128'(pend5), 128'h3);
        pulse(4'b0011, 1'b1);
        check("s5_heads", 128'(head5[63:0]), 128'h0000_0000_CAFE_0000);
        check("s5_valid", 128'(valid5), 128'h3);
        check("dflt_untouched", 128'(pend), 128'h0);
        sel5 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
